// File: rtl/mem_pkg.sv
// Shared definitions for the cpu memory/IO controller: command encodings,
// controller FSM states and the address decode helper.
package mem_pkg;

    // The cpu drives these encodings on mem_cmd.
    typedef enum logic [1:0] {
        MNONE    = 2'b00,
        MREAD    = 2'b01,
        MWRITE   = 2'b10,
        MILLEGAL = 2'b11
    } mem_cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } mem_state_e;

    typedef enum logic [1:0] {
        DEC_RAM,
        DEC_LED,
        DEC_SW,
        DEC_NONE
    } mem_dec_e;

    localparam logic [8:0] LED_ADDR_DEF = 9'h100;
    localparam logic [8:0] SW_ADDR_DEF  = 9'h140;

    // RAM wins over the IO registers should a parameter set ever overlap them.
    function automatic mem_dec_e decode_addr(input logic [8:0] addr,
                                             input int         ram_words,
                                             input logic [8:0] led_addr,
                                             input logic [8:0] sw_addr);
        if (int'(addr) < ram_words) return DEC_RAM;
        if (addr == led_addr)       return DEC_LED;
        if (addr == sw_addr)        return DEC_SW;
        return DEC_NONE;
    endfunction

endpackage

// File: rtl/ram_sp.sv
// Single-port synchronous RAM, 16-bit words. The read port register only
// updates on read accesses so it holds the last loaded word.
module ram_sp #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [15:0]   wdata,
    output logic [15:0]   rdata
);

    logic [15:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// Memory/IO controller behind the cpu: on-chip RAM, LED register, switch
// register, programmable wait states and a sticky bus error flag.
module mem_ctrl
    import mem_pkg::*;
#(
    parameter int         RAM_WORDS   = 256,
    parameter int         WAIT_STATES = 0,
    parameter logic [8:0] LED_ADDR    = LED_ADDR_DEF,
    parameter logic [8:0] SW_ADDR     = SW_ADDR_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  mem_cmd,
    input  logic [8:0]  mem_addr,
    input  logic [15:0] write_data,
    output logic [15:0] read_data,
    output logic        mem_ready,
    input  logic [7:0]  sw,
    output logic [7:0]  led,
    output logic        bus_err
);

    mem_state_e  state_reg, state_next;
    logic        accept, commit, illegal_cmd;
    logic        wr_reg;
    logic [8:0]  addr_reg;
    logic [15:0] data_reg;
    logic [3:0]  cnt_reg;
    logic [7:0]  sw_meta_reg, sw_sync_reg;
    logic [7:0]  led_reg;
    logic        err_reg;
    logic [15:0] io_rdata_reg;
    logic        rsel_ram_reg;
    logic [15:0] ram_rdata;
    mem_dec_e    dec;
    logic        access_err;

    assign dec        = decode_addr(addr_reg, RAM_WORDS, LED_ADDR, SW_ADDR);
    assign access_err = (dec == DEC_NONE) || (dec == DEC_SW && wr_reg);

    always_comb begin
        state_next  = state_reg;
        accept      = 1'b0;
        commit      = 1'b0;
        illegal_cmd = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (mem_cmd == MREAD || mem_cmd == MWRITE) begin
                    accept     = 1'b1;
                    state_next = ST_ACCESS;
                end else if (mem_cmd == MILLEGAL) begin
                    illegal_cmd = 1'b1;
                end
            end
            ST_ACCESS: begin
                if (cnt_reg == 4'd0) begin
                    commit     = 1'b1;
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 4'd0;
            wr_reg    <= 1'b0;
            addr_reg  <= 9'd0;
            data_reg  <= 16'd0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                cnt_reg  <= 4'(WAIT_STATES);
                wr_reg   <= (mem_cmd == MWRITE);
                addr_reg <= mem_addr;
                data_reg <= write_data;
            end else if (state_reg == ST_ACCESS && cnt_reg != 4'd0) begin
                cnt_reg <= cnt_reg - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_meta_reg <= 8'd0;
            sw_sync_reg <= 8'd0;
        end else begin
            sw_meta_reg <= sw;
            sw_sync_reg <= sw_meta_reg;
        end
    end

    // RAM reads land in the RAM's own output register; IO reads land in
    // io_rdata_reg. rsel_ram_reg records which of the two holds the last read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led_reg      <= 8'd0;
            err_reg      <= 1'b0;
            io_rdata_reg <= 16'd0;
            rsel_ram_reg <= 1'b0;
        end else begin
            if (illegal_cmd || (commit && access_err)) begin
                err_reg <= 1'b1;
            end
            if (commit && wr_reg && dec == DEC_LED) begin
                led_reg <= data_reg[7:0];
            end
            if (commit && !wr_reg) begin
                rsel_ram_reg <= (dec == DEC_RAM);
                case (dec)
                    DEC_LED: io_rdata_reg <= {8'd0, led_reg};
                    DEC_SW:  io_rdata_reg <= {8'd0, sw_sync_reg};
                    default: io_rdata_reg <= 16'd0;
                endcase
            end
        end
    end

    ram_sp #(
        .DEPTH (RAM_WORDS),
        .AW    (8)
    ) u_ram (
        .clk   (clk),
        .en    (commit && dec == DEC_RAM),
        .we    (wr_reg),
        .addr  (addr_reg[7:0]),
        .wdata (data_reg),
        .rdata (ram_rdata)
    );

    assign read_data = rsel_ram_reg ? ram_rdata : io_rdata_reg;
    assign mem_ready = (state_reg == ST_RESP);
    assign led       = led_reg;
    assign bus_err   = err_reg;

endmodule

// File: tb/tb_mem_ctrl.sv
// Randomized check of mem_ctrl at WAIT_STATES=0 (instance 0) and 3 (instance 1)
// against a transaction-level model of RAM, LED, switches and bus_err.
module tb_mem_ctrl;

    localparam logic [1:0] C_NONE  = 2'b00;
    localparam logic [1:0] C_READ  = 2'b01;
    localparam logic [1:0] C_WRITE = 2'b10;
    localparam logic [1:0] C_ILL   = 2'b11;
    localparam logic [8:0] LED_A   = 9'h100;
    localparam logic [8:0] SW_A    = 9'h140;

    logic              clk;
    logic [1:0]        rst_n;
    logic [1:0][1:0]   cmd;
    logic [1:0][8:0]   addr;
    logic [1:0][15:0]  wdata;
    logic [1:0][15:0]  rdata;
    logic [1:0]        rdy;
    logic [1:0][7:0]   sw;
    logic [1:0][7:0]   led;
    logic [1:0]        berr;

    int total = 0;
    int bad   = 0;

    logic [15:0] ram_m [2][256];
    logic [7:0]  led_m [2];
    logic        err_m [2];
    logic [15:0] rd_m  [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        mem_ctrl #(
            .RAM_WORDS   (256),
            .WAIT_STATES ((gi == 0) ? 0 : 3),
            .LED_ADDR    (LED_A),
            .SW_ADDR     (SW_A)
        ) u_dut (
            .clk        (clk),
            .reset      (rst_n[gi]),
            .mem_cmd    (cmd[gi]),
            .mem_addr   (addr[gi]),
            .write_data (wdata[gi]),
            .read_data  (rdata[gi]),
            .mem_ready  (rdy[gi]),
            .sw         (sw[gi]),
            .led        (led[gi]),
            .bus_err    (berr[gi])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int wait_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    // Model of one completed access, applied at the mem_ready cycle.
    task automatic model_access(input int d, input logic [1:0] c, input logic [8:0] a,
                                input logic [15:0] dat);
        if (c == C_READ) begin
            if (a < 9'd256)     rd_m[d] = ram_m[d][a[7:0]];
            else if (a == LED_A) rd_m[d] = {8'h00, led_m[d]};
            else if (a == SW_A)  rd_m[d] = {8'h00, sw[d]};
            else begin
                rd_m[d]  = 16'h0000;
                err_m[d] = 1'b1;
            end
        end else begin
            if (a < 9'd256)      ram_m[d][a[7:0]] = dat;
            else if (a == LED_A) led_m[d] = dat[7:0];
            else                 err_m[d] = 1'b1;
        end
    endtask

    task automatic access(input int d, input logic [1:0] c, input logic [8:0] a,
                          input logic [15:0] dat);
        int k;
        logic [15:0] rd_before;
        @(negedge clk);
        cmd[d]   = c;
        addr[d]  = a;
        wdata[d] = dat;
        @(posedge clk);
        #1;
        if (c == C_ILL) begin
            cmd[d]   = C_NONE;
            err_m[d] = 1'b1;
            chk("ill_err", berr[d], err_m[d]);
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                chk("ill_no_ready", rdy[d], 1'b0);
            end
        end else begin
            // Latched copy must be used: disturb the bus after the accept edge.
            addr[d]   = 9'($urandom);
            wdata[d]  = 16'($urandom);
            rd_before = rd_m[d];
            k = 0;
            while (1) begin
                @(negedge clk);
                k++;
                if (rdy[d] === 1'b1 || k > 30) break;
                chk("rd_hold", rdata[d], rd_before);
            end
            chk("latency", k, 2 + wait_of(d));
            model_access(d, c, a, dat);
            cmd[d] = C_NONE;
            $display("dut%0d %s addr=%h data=%h rd=%h led=%h err=%0d lat=%0d", d,
                     (c == C_READ) ? "RD" : "WR", a, dat, rdata[d], led[d], berr[d], k);
            chk("read_data", rdata[d], rd_m[d]);
            chk("led", led[d], led_m[d]);
            chk("bus_err", berr[d], err_m[d]);
            @(negedge clk);
            chk("ready_pulse", rdy[d], 1'b0);
        end
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear without an edge.
    task automatic async_reset(input int d);
        @(posedge clk);
        #3;
        rst_n[d] = 1'b0;
        #1;
        led_m[d] = 8'h00;
        err_m[d] = 1'b0;
        rd_m[d]  = 16'h0000;
        chk("rst_rd", rdata[d], 16'h0000);
        chk("rst_rdy", rdy[d], 1'b0);
        chk("rst_led", led[d], 8'h00);
        chk("rst_err", berr[d], 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n[d] = 1'b1;
    endtask

    task automatic set_sw(input int d, input logic [7:0] v);
        @(negedge clk);
        sw[d] = v;
        repeat (3) @(negedge clk);
    endtask

    task automatic directed(input int d);
        access(d, C_WRITE, 9'h005, 16'hD005);
        access(d, C_READ, 9'h005, 16'h0000);
        access(d, C_WRITE, LED_A, 16'h12A5);
        set_sw(d, 8'h3C);
        access(d, C_READ, SW_A, 16'h0000);
        access(d, C_READ, LED_A, 16'h0000);
        access(d, C_WRITE, 9'h0FF, 16'hBEEF);
        access(d, C_READ, 9'h0FF, 16'h0000);
        chk("err_clean", berr[d], 1'b0);
        access(d, C_READ, 9'h1FF, 16'h0000);
        access(d, C_READ, 9'h005, 16'h0000);
        access(d, C_WRITE, SW_A, 16'h00FF);
        access(d, C_ILL, 9'h005, 16'h0000);
    endtask

    // Reset lands while a write is still waiting in ACCESS; the write must not commit.
    task automatic aborted_write(input int d);
        access(d, C_WRITE, 9'h010, 16'h1111);
        @(negedge clk);
        cmd[d]   = C_WRITE;
        addr[d]  = 9'h010;
        wdata[d] = 16'hDEAD;
        @(posedge clk);
        @(negedge clk);
        chk("abort_rdy_a", rdy[d], 1'b0);
        #1;
        rst_n[d] = 1'b0;
        cmd[d]   = C_NONE;
        led_m[d] = 8'h00;
        err_m[d] = 1'b0;
        rd_m[d]  = 16'h0000;
        #1;
        chk("abort_rdy_b", rdy[d], 1'b0);
        @(negedge clk);
        rst_n[d] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort_no_ready", rdy[d], 1'b0);
        end
        access(d, C_READ, 9'h010, 16'h0000);
    endtask

    task automatic random_run(input int d, input int n);
        logic [8:0]  a;
        logic [15:0] v;
        logic [1:0]  c;
        for (int i = 0; i < 32; i++) access(d, C_WRITE, 9'(i), 16'($urandom));
        access(d, C_WRITE, 9'h0FF, 16'($urandom));
        for (int i = 0; i < n; i++) begin
            int kind;
            kind = int'($urandom_range(0, 19));
            c    = ($urandom_range(0, 1) == 0) ? C_READ : C_WRITE;
            v    = 16'($urandom);
            if (kind < 10)       a = 9'($urandom_range(0, 31));
            else if (kind < 12)  a = 9'h0FF;
            else if (kind < 15)  a = LED_A;
            else if (kind < 17) begin
                a = SW_A;
                c = C_READ;
                set_sw(d, 8'($urandom));
            end else if (kind < 18) a = SW_A;
            else if (kind < 19)  a = 9'h101 + 9'($urandom_range(0, 62));
            else begin
                a = 9'h000;
                c = C_ILL;
            end
            access(d, c, a, v);
        end
    endtask

    initial begin
        rst_n = 2'b00;
        cmd   = '0;
        addr  = '0;
        wdata = '0;
        sw    = '0;
        for (int d = 0; d < 2; d++) begin
            led_m[d] = 8'h00;
            err_m[d] = 1'b0;
            rd_m[d]  = 16'h0000;
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("init_rd", rdata[d], 16'h0000);
            chk("init_rdy", rdy[d], 1'b0);
            chk("init_led", led[d], 8'h00);
            chk("init_err", berr[d], 1'b0);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 2'b11;
        for (int d = 0; d < 2; d++) begin
            directed(d);
            async_reset(d);
            aborted_write(d);
            random_run(d, 60);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
